uart_msg_arbiter: RTL and testbench
===================================

Name: uart_msg_arbiter

Overview:
- Shares one uart_tx byte transmitter between REQ_NUM message sources, so a board-level IO test can report many pin labels over a single serial line.
- Each requester presents a fixed-length MSG_BYTES message and holds a level request.
- The arbiter grants requesters round-robin, latches the granted message, and feeds it byte by byte into the uart_tx send_en/send_busy/send_data handshake.
- It pulses done when the last byte's frame has finished.

Parameters:
- REQ_NUM, 8: number of requesters, 2..32.
- MSG_BYTES, 5: bytes per message, 1..16.
- IDX_W, $clog2(REQ_NUM): width of the grant index and the round-robin pointer.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  REQ_NUM  level request per requester.
- req_data  in  REQ_NUM*MSG_BYTES*8  message of requester i at bits [i*MSG_BYTES*8 +: MSG_BYTES*8]; most significant byte is sent first.
- grant  out  REQ_NUM  one-hot owner of the transmitter; all-zero when idle.
- grant_idx  out  IDX_W  index of the current owner; holds the last owner when idle.
- done  out  1  one-cycle pulse when the granted message has completed.
- send_en  out  1  byte strobe to uart_tx.
- send_data  out  8  byte to uart_tx.
- send_busy  in  1  uart_tx busy; high from the cycle after uart_tx samples send_en until its stop bit ends.

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - State returns to IDLE; grant=0, grant_idx=0, done=0, send_en=0, send_data=0, byte_cnt=0.
  - Round-robin pointer ptr=REQ_NUM-1, so requester 0 has top priority first.
  - Applies mid-message: the message is abandoned. A uart_tx frame already in flight is allowed to finish; the next send waits for send_busy=0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE:
  - If req has any bit set, select the first set bit searching ptr+1, ptr+2, ... with wrap modulo REQ_NUM.
  - Latch that requester's message into msg_r, set grant and grant_idx, byte_cnt=0, go to ISSUE.
  - Arbitration decision takes 1 cycle; grant appears the cycle after req is sampled.
- ISSUE:
  - If send_busy=0: send_en=1, send_data=msg_r byte (MSG_BYTES-1-byte_cnt), go to WAIT_HI.
  - Otherwise stay in ISSUE with send_en=0.
- WAIT_HI:
  - send_en returns to 0 on entry, so it is exactly one cycle wide.
  - Wait for send_busy=1, then go to WAIT_LO.
- WAIT_LO:
  - Wait for send_busy=0.
  - If byte_cnt==MSG_BYTES-1: done=1 for one cycle, grant=0, ptr=grant_idx, go to IDLE.
  - Otherwise: byte_cnt+1, go to ISSUE.
- Latency: ISSUE to send_en is 0 cycles when send_busy=0; inter-byte gap is 2 clk beyond the uart_tx frame time.
- The message is latched at grant. req_data changes or req deassertion during a message have no effect; the message completes and done still pulses.
- No preemption: new or higher-index requests wait until done.
- A requester still holding req after its done is rearbitrated behind every other active requester, i.e. it gets its turn last.
- Simultaneous done and new req in the same cycle: the new req is evaluated in IDLE on the next cycle using the updated ptr.
- REQ_NUM not a power of two: the search wraps at REQ_NUM; indexes ≥REQ_NUM are never granted.
- Exactly one requester is granted at any time; grant is zero in IDLE.

Test Plan:
- Reset then req=4'b0010, req_data[1] = "P20 \n" (REQ_NUM=4, MSG_BYTES=5, uart_tx 25 MHz/115200) -> grant=4'b0010 one cycle later; uart_tx line decodes 0x50,0x32,0x30,0x20,0x0A in order; one done pulse; grant returns to 0.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0,...; each message fully sent with no byte interleaving between requesters; done count equals grants.
- req[2] drops, and req_data[2] changes to "XXXX\n", right after grant -> original latched message still sent; done pulses.
- rst_n=0 for 1 cycle during byte 3 of a message -> grant=0 and send_en=0 next cycle; after the in-flight frame ends, a new req=4'b0001 is sent cleanly and the line decodes correctly.
- Model send_busy held high for 100 cycles when entering ISSUE -> send_en stays 0 until send_busy=0, then a single one-cycle send_en.
- req=4'b1000 arriving in the same cycle as done for requester 0 -> requester 3 is granted 1 cycle after IDLE is re-entered; no lost or duplicate grant.

Source files
------------

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter between
// REQ_NUM fixed-length message sources.
module uart_msg_arbiter #(
  parameter int REQ_NUM   = 8,
  parameter int MSG_BYTES = 5,
  parameter int IDX_W     = $clog2(REQ_NUM)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_NUM-1:0]             req,
  input  logic [REQ_NUM*MSG_BYTES*8-1:0] req_data,
  output logic [REQ_NUM-1:0]             grant,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           done,
  output logic                           send_en,
  output logic [7:0]                     send_data,
  input  logic                           send_busy
);

  localparam int MSG_W = MSG_BYTES * 8;
  localparam int CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t             state, state_n;
  logic [MSG_W-1:0]   msg_r, msg_n;
  logic [REQ_NUM-1:0] grant_n;
  logic [IDX_W-1:0]   idx_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   pick;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               done_n;
  logic [7:0]         cur_byte;

  // Lowest k wins: first requester after ptr, wrapping at REQ_NUM.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [REQ_NUM-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    int j;
    rr_pick = '0;
    for (int k = REQ_NUM; k >= 1; k--) begin
      j = (int'(p) + k) % REQ_NUM;
      if (r[j]) rr_pick = IDX_W'(j);
    end
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign cur_byte = msg_r[(MSG_BYTES - 1 - int'(cnt)) * 8 +: 8];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      done      <= 1'b0;
      cnt       <= '0;
      ptr       <= IDX_W'(REQ_NUM - 1);
      msg_r     <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      grant_idx <= idx_n;
      done      <= done_n;
      cnt       <= cnt_n;
      ptr       <= ptr_n;
      msg_r     <= msg_n;
    end
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    idx_n     = grant_idx;
    ptr_n     = ptr;
    cnt_n     = cnt;
    msg_n     = msg_r;
    done_n    = 1'b0;
    send_en   = 1'b0;
    send_data = 8'h00;
    unique case (state)
      IDLE: begin
        if (|req) begin
          msg_n   = req_data[int'(pick) * MSG_W +: MSG_W];
          grant_n = REQ_NUM'(1) << pick;
          idx_n   = pick;
          cnt_n   = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!send_busy) begin
          send_en   = 1'b1;
          send_data = cur_byte;
          state_n   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (send_busy) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!send_busy) begin
          if (cnt == CNT_W'(MSG_BYTES - 1)) begin
            done_n  = 1'b1;
            grant_n = '0;
            ptr_n   = grant_idx;
            state_n = IDLE;
          end else begin
            cnt_n   = cnt + CNT_W'(1);
            state_n = ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Randomized bench for uart_msg_arbiter with a message-level reference
// model and a behavioural uart_tx busy model.
module tb_uart_msg_arbiter;

  localparam int N  = 4;
  localparam int MB = 5;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*MB*8-1:0] req_data = '0;
  logic [N-1:0]      grant;
  logic [IW-1:0]     grant_idx;
  logic              done;
  logic              send_en;
  logic [7:0]        send_data;
  logic              send_busy = 1'b0;

  always #5 clk = ~clk;

  uart_msg_arbiter #(
    .REQ_NUM  (N),
    .MSG_BYTES(MB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .grant_idx(grant_idx),
    .done     (done),
    .send_en  (send_en),
    .send_data(send_data),
    .send_busy(send_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  bit                active;
  int                cur;
  int                ptr = N - 1;
  int                last_idx;
  int                pos;
  bit                frame_ok;
  bit                seen_hi;
  logic [7:0]        exp_b [MB];
  logic [N-1:0]      prev_req;
  logic [N*MB*8-1:0] prev_data;
  bit                prev_rst;
  bit                prev_busy;
  bit                prev_en;
  bit                done_now;
  int                busy_cnt;
  int                hold_cnt;
  int                n_grant;
  int                n_done;
  logic [7:0]        sent_q[$];
  int                gnt_q[$];

  function automatic int rr(int p, logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: inputs seen at the last posedge, busy for the next one,
  // then compare the DUT outputs against the model.
  task automatic step();
    bit busy_now;
    bit exp_done;
    bit exp_en;
    @(negedge clk);
    prev_req  = req;
    prev_data = req_data;
    prev_rst  = !rst_n;
    if (hold_cnt > 0) hold_cnt--;
    if (busy_cnt > 0) busy_cnt--;
    if (prev_en) busy_cnt = $urandom_range(1, 10);
    send_busy = (busy_cnt > 0) || (hold_cnt > 0);
    busy_now  = send_busy;
    #1;
    done_now = 1'b0;
    if (send_en) sent_q.push_back(send_data);
    if (prev_rst) begin
      check("rst_grant", grant, 0);
      check("rst_idx", grant_idx, 0);
      check("rst_done", done, 0);
      check("rst_en", send_en, 0);
      check("rst_data", send_data, 0);
      ptr      = N - 1;
      last_idx = 0;
      active   = 1'b0;
    end else begin
      if (active) begin
        if (prev_busy) seen_hi = 1'b1;
        if (seen_hi && !prev_busy) frame_ok = 1'b1;
      end
      exp_done = active && pos == MB && frame_ok;
      if (!active && prev_req != 0) begin
        cur = rr(ptr, prev_req);
        for (int b = 0; b < MB; b++)
          exp_b[b] = prev_data[cur*MB*8 + (MB-1-b)*8 +: 8];
        active   = 1'b1;
        pos      = 0;
        frame_ok = 1'b1;
        seen_hi  = 1'b0;
        last_idx = cur;
        n_grant++;
        gnt_q.push_back(cur);
      end
      check("done", done, exp_done);
      if (exp_done) begin
        active   = 1'b0;
        ptr      = cur;
        done_now = 1'b1;
        n_done++;
      end
      check("grant", grant, active ? (1 << cur) : 0);
      check("grant_idx", grant_idx, last_idx);
      exp_en = active && frame_ok && pos < MB && !busy_now;
      check("send_en", send_en, exp_en);
      if (send_en && exp_en) begin
        check("send_data", send_data, exp_b[pos]);
        pos++;
        frame_ok = 1'b0;
        seen_hi  = 1'b0;
      end
    end
    prev_busy = busy_now;
    prev_en   = send_en;
  endtask

  task automatic wait_idle(int max);
    int t = 0;
    while ((active || send_busy || hold_cnt > 0) && t < max) begin
      step();
      t++;
    end
    check("idle_timeout", t < max, 1);
    step();
  endtask

  task automatic set_msg(int i, logic [MB*8-1:0] m);
    req_data[i*MB*8 +: MB*8] = m;
  endtask

  task automatic check_sent(string tag, logic [MB*8-1:0] m);
    logic [MB*8-1:0] mm;
    mm = m;
    check({tag, "_len"}, sent_q.size(), MB);
    for (int b = 0; b < MB && b < sent_q.size(); b++)
      check(tag, sent_q[b], mm[(MB-1-b)*8 +: 8]);
  endtask

  initial begin
    logic [MB*8-1:0] m;
    int d0;
    int g0;
    int t;

    repeat (3) step();
    rst_n = 1'b1;
    step();

    // "P20 \n" from requester 1
    set_msg(1, 40'h503230200A);
    sent_q.delete();
    d0  = n_done;
    req = 4'b0010;
    step();
    check("p20_grant", grant, 4'b0010);
    req = '0;
    wait_idle(400);
    check_sent("p20_byte", 40'h503230200A);
    check("p20_done", n_done - d0, 1);
    check("p20_idle", grant, 0);

    // all requesting: strict rotation, no interleaving
    for (int i = 0; i < N; i++) set_msg(i, {$urandom, 8'(i)});
    gnt_q.delete();
    d0  = n_done;
    g0  = n_grant;
    req = '1;
    t   = 0;
    while (n_done - d0 < 12 && t < 3000) begin
      step();
      t++;
    end
    req = '0;
    wait_idle(400);
    check("rot_cnt", n_done - d0, n_grant - g0);
    for (int k = 0; k < 12 && k < gnt_q.size(); k++)
      check("rot_order", gnt_q[k], (2 + k) % N);

    // req drop and data change after grant
    m = {$urandom, 8'h5A};
    set_msg(2, m);
    sent_q.delete();
    d0  = n_done;
    req = 4'b0100;
    step();
    check("drop_grant", grant, 4'b0100);
    req = '0;
    set_msg(2, 40'h585858580A);
    wait_idle(400);
    check_sent("drop_byte", m);
    check("drop_done", n_done - d0, 1);

    // reset in the middle of a message
    set_msg(0, {$urandom, 8'h11});
    req = 4'b0001;
    t   = 0;
    while (!(active && pos == 3) && t < 400) begin
      step();
      t++;
    end
    check("mid_reach", t < 400, 1);
    rst_n = 1'b0;
    req   = '0;
    step();
    rst_n = 1'b1;
    step();
    check("mid_grant", grant, 0);
    check("mid_en", send_en, 0);
    m = {$urandom, 8'h22};
    set_msg(0, m);
    sent_q.delete();
    req = 4'b0001;
    step();
    req = '0;
    wait_idle(400);
    check_sent("mid_byte", m);

    // transmitter held busy long after grant
    set_msg(0, {$urandom, 8'h33});
    req      = 4'b0001;
    hold_cnt = 100;
    t        = 0;
    while (!send_en && t < 300) begin
      step();
      t++;
    end
    check("hold_len", t, 100);
    req = '0;
    step();
    check("hold_pulse", send_en, 0);
    wait_idle(400);

    // new request lands in the done cycle
    req = 4'b0001;
    step();
    req = '0;
    t   = 0;
    while (!done_now && t < 400) begin
      step();
      t++;
    end
    check("late_done", done_now, 1);
    g0  = n_grant;
    req = 4'b1000;
    step();
    check("late_grant", grant, 4'b1000);
    check("late_idx", grant_idx, 3);
    req = '0;
    wait_idle(400);
    check("late_once", n_grant - g0, 1);

    // random traffic with occasional reset
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      if ($urandom_range(0, 3) == 0)
        set_msg($urandom_range(0, N - 1), {$urandom, 8'($urandom)});
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end
    rst_n = 1'b1;
    req   = '0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
